// File: rtl/pwm_multi_core.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_core
// Description : MMIO PWM slot core. W channels share one 32-bit prescaler
//               and one R-bit period counter. Edge-aligned or center-aligned
//               counting. TOP, MODE and DUTY are double-buffered and are
//               applied only at period boundaries. Each channel has its own
//               enable and polarity. Every register can be read back.
// Ports       : clk_i      - system clock
//               reset_i    - synchronous reset, active low
//               cs_i       - slot select
//               read_i     - read strobe (reads have no side effects)
//               write_i    - write strobe; a write happens on cs_i && write_i
//               addr_i     - register address
//               wr_data_i  - write data
//               rd_data_o  - combinational readback; 0 for unmapped addresses
//               pwm_out_o  - registered PWM outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_core #(
    parameter int R = 10,
    parameter int W = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cs_i,
    input  logic          read_i,
    input  logic          write_i,
    input  logic [4:0]    addr_i,
    input  logic [31:0]   wr_data_i,
    output logic [31:0]   rd_data_o,
    output logic [W-1:0]  pwm_out_o
);

    localparam logic [4:0]   C_A_DVSR   = 5'h00;
    localparam logic [4:0]   C_A_TOP    = 5'h01;
    localparam logic [4:0]   C_A_CTRL   = 5'h02;
    localparam logic [4:0]   C_A_POL    = 5'h03;
    localparam logic [4:0]   C_A_CHEN   = 5'h04;
    localparam logic [4:0]   C_A_STATUS = 5'h05;
    localparam logic [4:0]   C_A_DUTY   = 5'h10;
    localparam logic [R-1:0] C_ONE      = {{(R-1){1'b0}}, 1'b1};

    // Software-visible shadow registers
    logic [31:0]  dvsr_q, dvsr_d;
    logic [R-1:0] top_q,  top_d;
    logic         en_q,   en_d;
    logic         mode_q, mode_d;
    logic [W-1:0] pol_q,  pol_d;
    logic [W-1:0] chen_q, chen_d;
    logic [R:0]   duty_q [W];
    logic [R:0]   duty_d [W];

    // Active copies that the counter and the compare logic use
    logic [R-1:0] top_a_q;
    logic         mode_a_q;
    logic [R:0]   duty_a_q [W];

    // Timebase
    logic [31:0]  q_q;
    logic [R-1:0] cnt_q, cnt_nx;
    logic         dir_q, dir_nx;
    logic [W-1:0] pwm_q, pwm_d;

    logic         tick;
    logic         boundary;
    logic         pending;

    // Reads have no side effects, so the read strobe is not used.
    logic         unused_read;
    assign unused_read = read_i;

    // Shadow next-state. The boundary and disabled-mode loads use these
    // values, so a write that lands on a boundary is picked up at once.
    always_comb begin
        dvsr_d = dvsr_q;
        top_d  = top_q;
        en_d   = en_q;
        mode_d = mode_q;
        pol_d  = pol_q;
        chen_d = chen_q;
        duty_d = duty_q;
        if (cs_i && write_i) begin
            case (addr_i)
                C_A_DVSR: dvsr_d = wr_data_i;
                C_A_TOP:  top_d  = wr_data_i[R-1:0];
                C_A_CTRL: begin
                    en_d   = wr_data_i[0];
                    mode_d = wr_data_i[1];
                end
                C_A_POL:  pol_d  = wr_data_i[W-1:0];
                C_A_CHEN: chen_d = wr_data_i[W-1:0];
                default: begin
                    for (int i = 0; i < W; i++) begin
                        if (addr_i == C_A_DUTY + 5'(i)) begin
                            duty_d[i] = wr_data_i[R:0];
                        end
                    end
                end
            endcase
        end
    end

    assign tick = en_q && (q_q == dvsr_q);

    // Counter next value for a tick. A center-mode counter with TOP_a = 0
    // falls back to edge behaviour, so it cannot stall.
    always_comb begin
        cnt_nx = cnt_q;
        dir_nx = dir_q;
        if (!mode_a_q || (top_a_q == '0)) begin
            dir_nx = 1'b0;
            cnt_nx = (cnt_q >= top_a_q) ? '0 : cnt_q + C_ONE;
        end else if (!dir_q) begin
            if (cnt_q >= top_a_q) begin
                cnt_nx = cnt_q - C_ONE;
                dir_nx = 1'b1;
            end else begin
                cnt_nx = cnt_q + C_ONE;
            end
        end else begin
            // Reaching 0 on the way down is a boundary, which resets dir.
            cnt_nx = cnt_q - C_ONE;
        end
    end

    assign boundary = tick && (cnt_nx == '0);

    always_comb begin
        pending = (top_q != top_a_q) || (mode_q != mode_a_q);
        for (int i = 0; i < W; i++) begin
            if (duty_q[i] != duty_a_q[i]) begin
                pending = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < W; i++) begin
            if (chen_q[i] && en_q) begin
                pwm_d[i] = ({1'b0, cnt_q} < duty_a_q[i]) ^ pol_q[i];
            end else begin
                pwm_d[i] = pol_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            dvsr_q   <= '0;
            top_q    <= '0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            pol_q    <= '0;
            chen_q   <= '0;
            top_a_q  <= '0;
            mode_a_q <= 1'b0;
            q_q      <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            pwm_q    <= '0;
            for (int i = 0; i < W; i++) begin
                duty_q[i]   <= '0;
                duty_a_q[i] <= '0;
            end
        end else begin
            dvsr_q <= dvsr_d;
            top_q  <= top_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            pol_q  <= pol_d;
            chen_q <= chen_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            if (!en_q) begin
                // While disabled the active copies are transparent.
                q_q      <= '0;
                cnt_q    <= '0;
                dir_q    <= 1'b0;
                top_a_q  <= top_d;
                mode_a_q <= mode_d;
                duty_a_q <= duty_d;
            end else if (tick) begin
                q_q <= '0;
                if (boundary) begin
                    cnt_q    <= '0;
                    dir_q    <= 1'b0;
                    top_a_q  <= top_d;
                    mode_a_q <= mode_d;
                    duty_a_q <= duty_d;
                end else begin
                    cnt_q <= cnt_nx;
                    dir_q <= dir_nx;
                end
            end else begin
                // This wraps at 2^32 if DVSR was lowered below q while enabled.
                q_q <= q_q + 32'd1;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (addr_i)
            C_A_DVSR:   rd_data_o = dvsr_q;
            C_A_TOP:    rd_data_o[R-1:0] = top_q;
            C_A_CTRL:   rd_data_o[1:0] = {mode_q, en_q};
            C_A_POL:    rd_data_o[W-1:0] = pol_q;
            C_A_CHEN:   rd_data_o[W-1:0] = chen_q;
            C_A_STATUS: begin
                rd_data_o[R-1:0] = cnt_q;
                rd_data_o[R]     = dir_q;
                rd_data_o[R+1]   = pending;
            end
            default: begin
                for (int i = 0; i < W; i++) begin
                    if (addr_i == C_A_DUTY + 5'(i)) begin
                        rd_data_o[R:0] = duty_q[i];
                    end
                end
            end
        endcase
    end

    assign pwm_out_o = pwm_q;

endmodule
`default_nettype wire

// File: doc/pwm_multi_core.md
# pwm_multi_core

Next-generation MMIO PWM slot core. W independent channels share one prescaler and one R-bit period counter, with programmable period (TOP), edge-aligned or center-aligned counting, double-buffered duty/period/mode updates applied only at period boundaries, per-channel output enable and polarity, and full register readback. It sits in an MMIO subsystem slot alongside the existing cores and drives W external PWM pins.

## Interface
- R, 10: counter/duty resolution in bits. Duty registers are R+1 bits wide.
- W, 8: channel count, 1..16.
- clk  in  1  system clock, sole clock domain.
- reset  in  1  synchronous, active-low reset. Sampled on rising clk; 0 resets.
- cs  in  1  slot select.
- read  in  1  read strobe. Reads have no side effects.
- write  in  1  write strobe. Write happens when cs && write.
- addr  in  5  register address.
- wr_data  in  32  write data.
- rd_data  out  32  combinational readback of the addressed register; 0 for unmapped addresses.
- pwm_out  out  W  registered PWM outputs.

## Operation
- Register map (reads return the stored value, zero-extended):
  - 0x00 DVSR[31:0]: prescale divisor.
  - 0x01 TOP[R-1:0]: period shadow.
  - 0x02 CTRL: bit0 EN (global, immediate); bit1 MODE shadow (0 = edge, 1 = center).
  - 0x03 POL[W-1:0]: per-channel polarity, immediate.
  - 0x04 CHEN[W-1:0]: per-channel enable, immediate.
  - 0x05 STATUS, read-only: [R-1:0] cnt; bit R dir (1 = down); bit R+1 pending (some shadow differs from its active copy).
  - 0x10+i, for i < W: DUTY_i[R:0] shadow. Writes with i ≥ W are ignored.
- Prescaler:
  - q counts 0..DVSR while EN = 1.
  - tick = EN && (q == DVSR); on tick, q returns to 0.
  - Each counter value therefore lasts DVSR+1 clocks.
- Edge mode: on each tick, cnt counts 0,1,…,TOP_a, then wraps to 0. Period = (TOP_a+1)·(DVSR+1) clocks.
- Center mode:
  - Sequence 0,1,…,TOP_a,TOP_a−1,…,1, then repeats.
  - dir flips at cnt = TOP_a (going up) and at cnt = 0 (going down).
  - Period = 2·TOP_a ticks.
  - If TOP_a = 0, behaves as edge mode (cnt stays 0).
- Boundary:
  - Defined as tick && (next cnt == 0).
  - At a boundary, TOP_a ← TOP, MODE_a ← MODE, and DUTY_a[i] ← DUTY[i] for all i.
  - The new values apply from the cycle in which cnt = 0.
  - The counter is restarted at 0 with dir = up.
- Compare:
  - raw_i = ({1'b0,cnt} < DUTY_a[i]), using unsigned R+1-bit compare.
  - DUTY_a ≥ TOP_a+1 gives constant high. DUTY_a = 0 gives constant low.
- Output: pwm_next_i = CHEN_i && EN ? raw_i ^ POL_i : POL_i. pwm_out is registered from pwm_next.
- EN = 0 (disabled):
  - q and cnt are held at 0, dir = up.
  - Active copies track their shadows every cycle, so they are transparent.
  - Outputs sit at their POL level.
- Simultaneous events:
  - A shadow write in the same cycle as a boundary: the newly written value is loaded at that boundary.
  - A DVSR write takes effect immediately. If q > new DVSR, q continues counting up and wraps at 2^32 back to 0. Software must write DVSR only while EN = 0.

## Timing
- Reset (reset = 0 at a clk edge): every register is 0. This includes q, cnt, dir, shadows, active copies, POL and CHEN. pwm_out = 0 on the following cycle.
- Register write: visible on rd_data in the next cycle.
- Immediate registers (EN, POL, CHEN): affect pwm_next in the next cycle, and pwm_out one cycle after that.
- Output latency: pwm_out reflects cnt/dir/active state with a one-clock lag.
- EN 0→1 with DVSR = d: the first tick occurs d+1 clocks after the EN write lands, so cnt = 0 lasts a full tick interval.
- Reset asserted mid-period: all state clears at that edge. Counting resumes only after software sets EN again.

## Test plan
- Edge mode, DVSR = 0, TOP = 9, DUTY_0 = 3, CHEN = 1, EN = 1 -> pwm_out[0] is high 3 clocks and low 7 clocks, with a 10-clock period, repeating; STATUS cnt cycles 0..9.
- Center mode, DVSR = 1, TOP = 4, DUTY_0 = 2 -> cnt sequence 0,1,2,3,4,3,2,1, each value held 2 clocks; output high for cnt ∈ {0,1}, i.e. 6 of 16 clocks, symmetric about cnt = 0.
- Double buffering: edge mode, TOP = 9, DUTY_0 = 3. Write DUTY_0 = 7 at cnt = 5 -> the rest of the current period still uses 3 and pending reads 1; the next period is high for 7 clocks and pending clears. Also write at the exact boundary cycle -> the new value applies immediately.
- Extremes: DUTY = 0 -> constant low. DUTY = TOP+1 and DUTY = 2^R -> constant high. TOP = 0 in center mode -> no hang, and it behaves as edge mode.
- Polarity/enable: POL = 0x01 with CHEN = 0 -> pwm_out[0] = 1 constant. With CHEN = 1 -> the inverted waveform. Writing EN = 0 mid-period -> outputs return to their POL levels and cnt reads 0 two cycles later.
- Reset mid-operation, plus writes to unmapped addresses (0x06, 0x10+W) -> pwm_out = 0 and all reads return 0 after reset; unmapped writes change no register.
